// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle between the CPU data-memory port
// (master) and the data-memory controller (slave).
interface dmem_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic              we;
    logic              sign;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              addr_err;

    modport master (
        output req, we, sign, size, addr, wdata,
        input  busy, rvalid, rdata, addr_err
    );

    modport slave (
        input  req, we, sign, size, addr, wdata,
        output busy, rvalid, rdata, addr_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: fixed-latency byte/half/word data-memory controller.
// A request is captured while idle, the access happens LAT edges later, and
// loads return extended data with a one-cycle rvalid pulse.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned or non-one-hot requests
// are suppressed at the access edge and reported with an addr_err pulse.
// Without it, low address bits are ignored per access size and a
// non-one-hot size behaves as a word access.
module dmem_ctrl #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    localparam int         DEPTH = 1 << (ADDR_W - 2);
    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              busy_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              addr_err_q;

    // Request captured at accept; data-only, never reset.
    logic              we_q;
    logic              sign_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem [DEPTH];

    logic              is_byte;
    logic              is_half;
    logic              illegal;
    logic              access_edge;
    logic              mem_we;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       rd_word;

    // Pick the addressed lane(s) out of a little-endian word and extend them.
    function automatic logic [31:0] fmt_load(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic        is_b,
        input logic        is_h,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        if (is_b) begin
            res = {{24{sgn & b[7]}}, b};
        end else if (is_h) begin
            res = {{16{sgn & h[15]}}, h};
        end else begin
            res = w;
        end
        return res;
    endfunction

    // Decode the captured request: size class, legality, lane enables.
    always_comb begin
        is_byte  = (size_q == 3'b001);
        is_half  = (size_q == 3'b010);
        word_idx = addr_q[ADDR_W-1:2];
        rd_word  = mem[word_idx];
`ifdef DMEM_MISALIGN_TRAP_EN
        illegal  = !(size_q == 3'b001 || size_q == 3'b010 || size_q == 3'b100)
                   || (is_half && addr_q[0])
                   || ((size_q == 3'b100) && (addr_q[1:0] != 2'b00));
`else
        illegal  = 1'b0;
`endif
        access_edge = (state_q == ACTIVE) && (cnt_q == 4'd1);
        mem_we      = access_edge && we_q && !illegal && !rst;

        wr_be   = 4'b1111;
        wr_data = wdata_q;
        if (is_byte) begin
            wr_be   = 4'b0001 << addr_q[1:0];
            wr_data = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata_q[15:0]}};
        end
    end

    // Capture request fields whenever a request is accepted.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.req) begin
            we_q    <= bus.we;
            sign_q  <= bus.sign;
            size_q  <= bus.size;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Byte-lane store into the word array at the access edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Control FSM: accept, count down LAT edges, complete with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        cnt_q   <= LAT_C;
                        busy_q  <= 1'b1;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (access_edge) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (illegal) begin
                            addr_err_q <= 1'b1;
                        end else if (!we_q) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= fmt_load(rd_word, addr_q[1:0], is_byte,
                                                 is_half, sign_q);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl against a
// byte-array reference model. Honours DMEM_MISALIGN_TRAP_EN if defined.
module tb_dmem_ctrl;
    localparam int ADDR_W = 12;
    localparam int LAT_A  = 2;
    localparam int LAT_B  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus_a ();
    dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus_b ();

    dmem_ctrl #(.ADDR_W(ADDR_W), .LAT(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dmem_ctrl #(.ADDR_W(ADDR_W), .LAT(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int total = 0;
    int bad   = 0;

    logic [7:0]  mref [256];
    logic [31:0] rd_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic bit illegal_req(input logic [2:0] sz, input logic [7:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return !(sz == 3'd1 || sz == 3'd2 || sz == 3'd4)
               || (sz == 3'd2 && (int'(a) % 2) != 0)
               || (sz == 3'd4 && (int'(a) % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        if (sz == 3'd1) return 1;
        if (sz == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] sz,
                                             input logic sgn);
        int n = nbytes(sz);
        int base = int'(a) - (int'(a) % n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mref[base + i]) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        int base = int'(a) - (int'(a) % n);
        for (int i = 0; i < n; i++) mref[base + i] = 8'(wd >> (8 * i));
    endtask

    // One complete request on DUT A with busy/rvalid/rdata/addr_err checks.
    task automatic txn_a(input logic we, input logic sgn, input logic [2:0] sz,
                         input logic [7:0] a, input logic [31:0] wd, input string tag);
        bit          ill    = illegal_req(sz, a);
        logic        exp_rv = !we && !ill;
        logic [31:0] exp_rd = exp_rv ? ref_load(a, sz, sgn) : rd_hold;
        if (we && !ill) ref_store(a, sz, wd);
        @(negedge clk);
        bus_a.req   = 1'b1;
        bus_a.we    = we;
        bus_a.sign  = sgn;
        bus_a.size  = sz;
        bus_a.addr  = ADDR_W'(a);
        bus_a.wdata = wd;
        @(negedge clk);
        bus_a.req = 1'b0;
        chk({tag, "_busy"}, 32'(bus_a.busy), 32'd1);
        chk({tag, "_rv_lo"}, 32'(bus_a.rvalid), 32'd0);
        for (int i = 1; i < LAT_A; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(bus_a.busy), 32'd1);
        end
        @(negedge clk);
        chk({tag, "_idle"}, 32'(bus_a.busy), 32'd0);
        chk({tag, "_rvalid"}, 32'(bus_a.rvalid), 32'(exp_rv));
        chk({tag, "_err"}, 32'(bus_a.addr_err), 32'(ill));
        chk({tag, "_rdata"}, bus_a.rdata, exp_rd);
        rd_hold = exp_rd;
    endtask

    initial begin
        logic [31:0] old_w;
        logic [11:0] busy_obs;
        logic [11:0] busy_exp;
        logic [2:0]  sz;
        int          r;
        int          last_k;

        rst = 1'b1;
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.sign = 1'b0; bus_a.size = 3'b100;
        bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.sign = 1'b0; bus_b.size = 3'b100;
        bus_b.addr = '0; bus_b.wdata = '0;
        rd_hold = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_rvalid", 32'(bus_a.rvalid), 32'd0);
        chk("rst_rdata", bus_a.rdata, 32'd0);
        chk("rst_err", 32'(bus_a.addr_err), 32'd0);
        chk("rst_b_busy", 32'(bus_b.busy), 32'd0);
        rst = 1'b0;

        // Fill the modelled window with known words.
        for (int w = 0; w < 64; w++) txn_a(1'b1, 1'b0, 3'b100, 8'(w * 4), $urandom, "fill");

        // Word store then load.
        txn_a(1'b1, 1'b0, 3'b100, 8'h10, 32'hDEAD_BEEF, "t1_st");
        txn_a(1'b0, 1'b0, 3'b100, 8'h10, 32'd0, "t1_ld");
        chk("t1_const", bus_a.rdata, 32'hDEAD_BEEF);

        // Byte store into an existing word, signed/unsigned loads.
        txn_a(1'b1, 1'b0, 3'b100, 8'h10, 32'h1122_3344, "t2_init");
        txn_a(1'b1, 1'b0, 3'b001, 8'h13, 32'h0000_0080, "t2_stb");
        txn_a(1'b0, 1'b1, 3'b001, 8'h13, 32'd0, "t2_lbs");
        chk("t2_lbs_const", bus_a.rdata, 32'hFFFF_FF80);
        txn_a(1'b0, 1'b0, 3'b001, 8'h13, 32'd0, "t2_lbu");
        chk("t2_lbu_const", bus_a.rdata, 32'h0000_0080);
        txn_a(1'b0, 1'b0, 3'b100, 8'h10, 32'd0, "t2_lw");
        chk("t2_lw_const", bus_a.rdata, 32'h8022_3344);

        // Half store into the upper half of a word.
        txn_a(1'b1, 1'b0, 3'b010, 8'h22, 32'h0000_BEEF, "t3_sth");
        txn_a(1'b0, 1'b1, 3'b010, 8'h22, 32'd0, "t3_lhs");
        chk("t3_lhs_const", bus_a.rdata, 32'hFFFF_BEEF);
        txn_a(1'b0, 1'b0, 3'b100, 8'h20, 32'd0, "t3_lw");
        chk("t3_upper_const", {16'd0, bus_a.rdata[31:16]}, 32'h0000_BEEF);

        // Misaligned word load.
        txn_a(1'b0, 1'b0, 3'b100, 8'h11, 32'd0, "t6_mis");
`ifndef DMEM_MISALIGN_TRAP_EN
        chk("t6_const", bus_a.rdata, 32'h8022_3344);
`endif

        // Reset one cycle after a store accept aborts the store.
        old_w = ref_load(8'h40, 3'b100, 1'b0);
        @(negedge clk);
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.size = 3'b100;
        bus_a.addr = ADDR_W'(12'h040); bus_a.wdata = ~old_w;
        @(negedge clk);
        bus_a.req = 1'b0;
        rst = 1'b1;
        chk("t5_busy", 32'(bus_a.busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_busy", 32'(bus_a.busy), 32'd0);
        chk("t5_rst_rvalid", 32'(bus_a.rvalid), 32'd0);
        chk("t5_rst_rdata", bus_a.rdata, 32'd0);
        chk("t5_rst_err", 32'(bus_a.addr_err), 32'd0);
        rd_hold = 32'd0;
        txn_a(1'b0, 1'b0, 3'b100, 8'h40, 32'd0, "t5_ld");
        chk("t5_old_word", bus_a.rdata, old_w);

        // Randomized mix, including misaligned and non-one-hot sizes.
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 7);
            if (r < 6) sz = (r % 3 == 0) ? 3'b001 : ((r % 3 == 1) ? 3'b010 : 3'b100);
            else sz = 3'($urandom_range(0, 7));
            txn_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                  8'($urandom_range(0, 255)), $urandom, "rnd");
        end

        // req held high on DUT B: accepts every LAT_B+1 edges, others dropped.
        @(negedge clk);
        bus_b.req = 1'b1; bus_b.we = 1'b1; bus_b.size = 3'b100;
        bus_b.addr = ADDR_W'(12'h080); bus_b.wdata = 32'hA000_0000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            busy_obs[k] = bus_b.busy;
            busy_exp[k] = (k % (LAT_B + 1)) != LAT_B;
            if (k == 11) bus_b.we = 1'b0;
            else bus_b.wdata = 32'hA000_0000 + 32'(k + 1);
        end
        @(negedge clk);
        bus_b.req = 1'b0;
        for (int i = 1; i < LAT_B; i++) @(negedge clk);
        @(negedge clk);
        last_k = (11 / (LAT_B + 1)) * (LAT_B + 1);
        chk("t4_busy_pattern", 32'(busy_obs), 32'(busy_exp));
        chk("t4_rvalid", 32'(bus_b.rvalid), 32'd1);
        chk("t4_last_store", bus_b.rdata, 32'hA000_0000 + 32'(last_k));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the multicycle CPU's data-memory port.
- Accepts one byte/half/word load or store request per handshake.
- Holds a byte-lane, little-endian word array and performs access after a fixed, parameterised latency.
- Returns sign- or zero-extended load data with a valid pulse.

Parameters:
ADDR_W, 12, byte-address width; array depth = 2^(ADDR_W-2) 32-bit words
LAT, 2, cycles from request accept to access completion; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  1  request strobe; sampled only while busy=0
we  input  1  1=store, 0=load; sampled with req
sign  input  1  load sign-extend enable; sampled with req
size  input  3  one-hot {word,half,byte}; sampled with req
addr  input  ADDR_W  byte address; sampled with req
wdata  input  32  store data, right-aligned; sampled with req
busy  output  1  request in flight; req ignored while high
rvalid  output  1  one-cycle pulse, load data valid on rdata
rdata  output  32  formatted load data; held until next load completes
addr_err  output  1  one-cycle pulse, misaligned/illegal request (see Optional Feature)

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy=0, rvalid=0, rdata=0, addr_err=0, FSM=IDLE, counter=0.
- Array contents are not reset.
- FSM states:
  - IDLE: busy=0. On an edge with req=1, latch we/sign/size/addr/wdata, load counter=LAT, go to ACTIVE.
  - ACTIVE: busy=1. Counter decrements each edge. On the edge where the counter reaches 0, perform the access and return to IDLE.
- Timing: accept at edge T0; access at edge T0+LAT; busy high for exactly LAT cycles.
- Back-to-back: earliest next accept is edge T0+LAT+1. req high while busy=1 is dropped, not queued.
- Store, little-endian, word index = addr[ADDR_W-1:2]:
  - byte: lane addr[1:0] <= wdata[7:0]
  - half: lanes {addr[1],1}:{addr[1],0} <= wdata[15:0]
  - word: all lanes <= wdata
  - Other lanes unchanged.
- Store commits at the access edge. A load accepted afterwards observes the stored value.
- Load:
  - At the access edge, rdata <= selected lane(s), extended by latched sign.
  - byte: bits[31:8] = sign ? lane[7] : 0. half: bits[31:16] = sign ? half[15] : 0. word: unchanged.
  - rvalid=1 for the single cycle after the access edge.
- Stores never assert rvalid and never change rdata.
- Reset mid-ACTIVE aborts the request: a pending store is not committed, and no rvalid is issued.
- Alignment/size legality is defined only by the Optional Feature.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Illegal requests are: half with addr[0]=1, word with addr[1:0]!=0, or size not one-hot.
  - An illegal request still occupies LAT cycles.
  - At its access edge it performs no array write and no rdata update.
  - rvalid stays 0; addr_err=1 for the following single cycle.
- Undefined:
  - addr_err tied 0.
  - Low address bits are ignored: word uses addr[1:0]=0, half uses addr[0]=0.
  - Non-one-hot size is treated as word.
  - Every request completes normally.

Test Plan:
1. LAT=2: store word 0xDEADBEEF @0x010, then load word @0x010 -> busy high 2 cycles per request; rvalid pulses 2 cycles after second accept with rdata=0xDEADBEEF.
2. Store byte 0x80 @0x013 over 0x11223344, then load byte sign=1 @0x013 -> 0xFFFFFF80. Same load with sign=0 -> 0x00000080. Word @0x010 reads 0x80223344.
3. Store half 0xBEEF @0x022, then load half sign=1 @0x022 -> 0xFFFFBEEF. Load word @0x020 -> upper half 0xBEEF, lower half unchanged.
4. req held high continuously, LAT=3 -> accepts exactly at T0, T0+4, T0+8. No request is lost while busy=0, none is accepted while busy=1.
5. Store accepted, rst asserted one cycle later -> all outputs at reset values next cycle; a subsequent load shows the old word unchanged.
6. With DMEM_MISALIGN_TRAP_EN, load word @0x011 -> addr_err pulse at T0+LAT+1, rvalid=0, rdata unchanged. Without the macro -> rvalid pulse with word @0x010.
